// File: rtl/his_builder_fsm.sv
// Histogram builder: bins photon timestamps per pixel over one acquisition and reports each pixel's peak bin centre.
// Optional macro HIS_IGNORE_SATURATED_EN: all-ones timestamps advance the counters but are not binned.
module his_builder_fsm #(
  parameter int NP                = 10,
  parameter int PIXEL_NUM_PER_RAM = 3,
  parameter int SAMPLES           = 2,
  parameter int CYCLES            = 2,
  parameter int BIN_BITS          = 4,
  parameter int CNT_W             = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          wrEn,
  input  logic [NP-1:0] data,
  output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM-1:0]
);

  localparam int BINS = 1 << BIN_BITS;
  localparam int SW   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int PW   = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
  localparam int CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int LOW  = NP - BIN_BITS - 1;

  // state  | meaning
  // ACCUM  | accepting words, binning them into the addressed pixel histogram
  // PEAK   | one cycle: register argmax per pixel, clear histograms and counters
  typedef enum logic {ACCUM = 1'b0, PEAK = 1'b1} state_t;

  state_t              stateQ, stateNext;
  logic [SW-1:0]       sampleCnt;
  logic [PW-1:0]       pixelCnt;
  logic [CW-1:0]       cycleCnt;
  logic [CNT_W-1:0]    hist [PIXEL_NUM_PER_RAM][BINS];
  logic [NP-1:0]       peakNext [PIXEL_NUM_PER_RAM];
  logic                accept, lastWord, satWord, countWord;
  logic [BIN_BITS-1:0] binIdx;

  assign accept   = (stateQ == ACCUM) && wrEn;
  assign lastWord = (sampleCnt == SW'(SAMPLES - 1)) &&
                    (pixelCnt == PW'(PIXEL_NUM_PER_RAM - 1)) &&
                    (cycleCnt == CW'(CYCLES - 1));
  assign satWord  = &data;

`ifdef HIS_IGNORE_SATURATED_EN
  assign countWord = ~satWord;
  assign binIdx    = data[NP-1 -: BIN_BITS];
`else
  // An all-ones word lands in the top bin like any other value.
  assign countWord = 1'b1;
  assign binIdx    = satWord ? '1 : data[NP-1 -: BIN_BITS];
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) stateQ <= ACCUM;
    else      stateQ <= stateNext;
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      ACCUM:   if (accept && lastWord) stateNext = PEAK;
      PEAK:    stateNext = ACCUM;
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sampleCnt <= '0;
      pixelCnt  <= '0;
      cycleCnt  <= '0;
    end else if (stateQ == PEAK) begin
      sampleCnt <= '0;
      pixelCnt  <= '0;
      cycleCnt  <= '0;
    end else if (accept) begin
      if (sampleCnt == SW'(SAMPLES - 1)) begin
        sampleCnt <= '0;
        if (pixelCnt == PW'(PIXEL_NUM_PER_RAM - 1)) begin
          pixelCnt <= '0;
          cycleCnt <= (cycleCnt == CW'(CYCLES - 1)) ? '0 : cycleCnt + 1'b1;
        end else begin
          pixelCnt <= pixelCnt + 1'b1;
        end
      end else begin
        sampleCnt <= sampleCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
        for (int b = 0; b < BINS; b++)
          hist[p][b] <= '0;
    end else if (stateQ == PEAK) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++)
        for (int b = 0; b < BINS; b++)
          hist[p][b] <= '0;
    end else if (accept && countWord && (hist[pixelCnt][binIdx] != '1)) begin
      hist[pixelCnt][binIdx] <= hist[pixelCnt][binIdx] + 1'b1;
    end
  end

  // Strict greater-than while scanning upward keeps the lowest bin on ties.
  always_comb begin
    logic [CNT_W-1:0]    bestCnt;
    logic [BIN_BITS-1:0] bestBin;
    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
      bestCnt = hist[p][0];
      bestBin = '0;
      for (int b = 1; b < BINS; b++) begin
        if (hist[p][b] > bestCnt) begin
          bestCnt = hist[p][b];
          bestBin = BIN_BITS'(b);
        end
      end
      peakNext[p] = (bestCnt == '0) ? '1 : (NP'({bestBin, 1'b1}) << LOW);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) peakResult[p] <= '1;
    end else if (stateQ == PEAK) begin
      for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) peakResult[p] <= peakNext[p];
    end
  end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Directed bench for his_builder_fsm: default instance plus a long-acquisition single-pixel instance for saturation.
module tb_his_builder_fsm;
  localparam int NP  = 10;
  localparam int PIX = 3;

  typedef logic [NP-1:0] acq_t [12];

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          wrEn = 1'b0;
  logic [NP-1:0] data = '0;
  logic [NP-1:0] peakResult [PIX-1:0];
  logic          satWrEn = 1'b0;
  logic [NP-1:0] satData = '0;
  logic [NP-1:0] satPeak [0:0];

  int checks = 0;
  int failures = 0;

  acq_t wordsA = '{10'd108, 10'd511, 10'd1022, 10'd1022, 10'd200, 10'd90,
                   10'd511, 10'd1023, 10'd90, 10'd90, 10'd90, 10'd90};
  acq_t wordsB = '{10'd300, 10'd500, 10'd50, 10'd1000, 10'd48, 10'd90,
                   10'd600, 10'd500, 10'd1000, 10'd1023, 10'd120, 10'd90};
  acq_t wordsSat = '{default: 10'd1023};

  his_builder_fsm dut (
    .clk(clk), .res(res), .wrEn(wrEn), .data(data), .peakResult(peakResult)
  );

  his_builder_fsm #(.PIXEL_NUM_PER_RAM(1), .CYCLES(20)) satDut (
    .clk(clk), .res(res), .wrEn(satWrEn), .data(satData), .peakResult(satPeak)
  );

  always #5 clk = ~clk;

  task automatic driveCycle(input logic en, input logic [NP-1:0] d);
    @(negedge clk);
    wrEn = en;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic runAcq(input acq_t w, input logic [11:0] gapMask);
    for (int i = 0; i < 12; i++) begin
      if (gapMask[i]) driveCycle(1'b0, 10'd1023);
      driveCycle(1'b1, w[i]);
    end
  endtask

  task automatic test_reset();
    logic [NP-1:0] expv [PIX] = '{10'd1023, 10'd1023, 10'd1023};
    #2 res = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL reset_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
    checks++;
    if (satPeak[0] !== 10'd1023) begin
      failures++;
      $display("FAIL reset_sat_peak got=%0d want=1023", satPeak[0]);
    end
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic test_basic();
    logic [NP-1:0] holdv [PIX] = '{10'd1023, 10'd1023, 10'd1023};
    logic [NP-1:0] expv [PIX]  = '{10'd480, 10'd96, 10'd96};
    runAcq(wordsA, 12'h000);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== holdv[p]) begin
        failures++;
        $display("FAIL basic_hold[%0d] got=%0d want=%0d", p, peakResult[p], holdv[p]);
      end
    end
    driveCycle(1'b0, 10'd0);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL basic_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
  endtask

  task automatic test_peak_drop();
    logic [NP-1:0] holdv [PIX] = '{10'd480, 10'd96, 10'd96};
    logic [NP-1:0] expv [PIX]  = '{10'd480, 10'd992, 10'd96};
    runAcq(wordsB, 12'h000);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== holdv[p]) begin
        failures++;
        $display("FAIL drop_hold[%0d] got=%0d want=%0d", p, peakResult[p], holdv[p]);
      end
    end
    // 13th word offered during PEAK must not enter the next acquisition
    driveCycle(1'b1, 10'd1023);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL drop_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
  endtask

  task automatic test_saturated_word();
`ifdef HIS_IGNORE_SATURATED_EN
    logic [NP-1:0] expv [PIX] = '{10'd1023, 10'd1023, 10'd1023};
`else
    logic [NP-1:0] expv [PIX] = '{10'd992, 10'd992, 10'd992};
`endif
    runAcq(wordsSat, 12'h000);
    driveCycle(1'b0, 10'd0);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL satword_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [NP-1:0] expv [PIX] = '{10'd480, 10'd96, 10'd96};
    runAcq(wordsA, 12'b1010_1010_0101);
    driveCycle(1'b0, 10'd0);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL gaps_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [NP-1:0] expv [PIX] = '{10'd480, 10'd96, 10'd96};
    for (int i = 0; i < 5; i++) driveCycle(1'b1, 10'd1000);
    @(negedge clk);
    wrEn = 1'b0;
    res = 1'b0;
    #2;
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== 10'd1023) begin
        failures++;
        $display("FAIL midreset_async[%0d] got=%0d want=1023", p, peakResult[p]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    runAcq(wordsA, 12'h000);
    driveCycle(1'b0, 10'd0);
    for (int p = 0; p < PIX; p++) begin
      checks++;
      if (peakResult[p] !== expv[p]) begin
        failures++;
        $display("FAIL midreset_peak[%0d] got=%0d want=%0d", p, peakResult[p], expv[p]);
      end
    end
  endtask

  task automatic test_saturation();
    // 15 words in bin 3, 20 in bin 2 (saturates to 15), 5 in bin 5: tie -> bin 2
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      satWrEn = 1'b1;
      satData = (i < 15) ? 10'd200 : (i < 35) ? 10'd150 : 10'd350;
    end
    @(posedge clk);
    #1;
    checks++;
    if (satPeak[0] !== 10'd1023) begin
      failures++;
      $display("FAIL sat_hold got=%0d want=1023", satPeak[0]);
    end
    @(negedge clk);
    satWrEn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (satPeak[0] !== 10'd160) begin
      failures++;
      $display("FAIL sat_peak got=%0d want=160", satPeak[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_peak_drop();
    test_saturated_word();
    test_gaps();
    test_mid_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/his_builder_fsm.md
HIS_BUILDER_FSM -- requirements
Module: his_builder_fsm

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and res.
REQ-002 Parameter NP, default 10: timestamp width in bits.
REQ-003 Parameter PIXEL_NUM_PER_RAM, default 3: number of pixels whose histograms share the input stream.
REQ-004 Parameter SAMPLES, default 2: consecutive timestamps per pixel per laser cycle.
REQ-005 Parameter CYCLES, default 2: laser cycles per acquisition.
REQ-006 Parameter BIN_BITS, default 4: histogram bin index width; bins = 2^BIN_BITS.
REQ-007 Parameter CNT_W, default 4: bin counter width.
REQ-008 Port clk, input, 1: rising-edge clock.
REQ-009 Port res, input, 1: asynchronous active-low reset.
REQ-010 Port wrEn, input, 1: data valid, sampled on the rising clk edge.
REQ-011 Port data, input, NP: photon timestamp.
REQ-012 Port peakResult, output, unpacked array [PIXEL_NUM_PER_RAM-1:0] of NP bits: registered peak timestamp per pixel.

Function
REQ-013 The word order SHALL be cycle-major, then pixel, then sample: word k maps to sample k mod SAMPLES, pixel (k/SAMPLES) mod PIXEL_NUM_PER_RAM, cycle k/(SAMPLES*PIXEL_NUM_PER_RAM).
REQ-014 An acquisition SHALL be exactly CYCLES*PIXEL_NUM_PER_RAM*SAMPLES accepted words (12 by default).
REQ-015 The FSM SHALL have two states: ACCUM and PEAK.
REQ-016 In ACCUM, each cycle with wrEn=1 SHALL accept data and advance the sample/pixel/cycle counters.
REQ-017 Each accepted word SHALL increment bin data[NP-1 -: BIN_BITS] of the addressed pixel's histogram.
REQ-018 Bin counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 A cycle in ACCUM with wrEn=0 SHALL change nothing.
REQ-020 Acceptance of the last word of an acquisition SHALL move the FSM ACCUM->PEAK on the same edge.
REQ-021 PEAK SHALL last exactly one cycle and then return to ACCUM.
REQ-022 During the PEAK cycle, wrEn and data SHALL be ignored and the counters SHALL not advance.
REQ-023 The peak search SHALL be combinational over all bins of all pixels.
REQ-024 On the edge leaving PEAK, each peakResult[p] SHALL load the centre of pixel p's argmax bin: {bin, 1'b1, (NP-BIN_BITS-1) zeros}.
REQ-025 On that same edge, all histograms and the counters SHALL clear.
REQ-026 peakResult SHALL therefore update one clk after the last word is accepted, and SHALL hold until the next acquisition completes.
REQ-027 On a count tie, the lowest bin index SHALL win.
REQ-028 A pixel with all bins zero SHALL output all ones, meaning no target.

Reset
REQ-029 res low SHALL immediately force state ACCUM, clear all counters and histograms, and set every peakResult to all ones.
REQ-030 Reset asserted mid-acquisition SHALL discard the partial acquisition; counting SHALL restart at word 0 after release.

Configuration
REQ-031 With macro HIS_IGNORE_SATURATED_EN defined, an all-ones data word SHALL advance the counters but not increment any bin.
REQ-032 Without HIS_IGNORE_SATURATED_EN, an all-ones data word SHALL be counted in the top bin like any other value.

Verification (HIS_IGNORE_SATURATED_EN defined, default parameters)
REQ-033 Reset, then words 108,511,1022,1022,200,90,511,1023,90,90,90,90 -> one clk later peakResult = {480,96,96}; pixel 1 resolves a bin-1/bin-15 tie to bin 1.
REQ-034 A 13th word (1023) presented in the PEAK cycle SHALL be dropped; the next acquisition 300,500,50,1000,48,90,600,500,1000,1023,120,90 -> peakResult = {480,992,96}.
REQ-035 Acquisition of twelve 1023 words -> all peakResult = 1023; the same stimulus without the macro -> all peakResult = 992.
REQ-036 res pulsed low after 5 words, then a full 12-word acquisition -> result reflects only the post-reset words; peakResult = 1023 while res is low.
REQ-037 Twenty words in bin 2 for one pixel (CNT_W=4, CYCLES raised to 20) versus 15 in bin 3 -> the counter saturates at 15, the tie resolves to bin 2 -> output 160.
REQ-038 wrEn gaps inside an acquisition -> the result is identical to gap-free input.
